// File: rtl/cond_unit_e.sv
// cond_unit_e: Execute-stage conditional unit. Holds the decode-to-execute
// control register and the NZCV flags, evaluates the condition field of the
// instruction in Execute and gates its side effects before Memory.
module cond_unit_e (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall_e,
  input  logic       flush_e,
  input  logic [3:0] CondD,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic       NoWriteD,
  input  logic [1:0] FlagWD,
  input  logic [3:0] ALUFlagsE,
  output logic       CondExE,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       BranchTakenE,
  output logic [3:0] FlagsE
);

  typedef struct packed {
    logic [3:0] cond;
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       nowrite;
    logic [1:0] flagw;
  } ex_ctrl_t;

  ex_ctrl_t   ex_d, ex_q;
  logic [3:0] flags_d, flags_q;
  logic       cond_ex;

  // Next Execute register contents: bubble on flush, hold on stall, else load.
  always_comb begin
    // NOTE: default first so every path assigns ex_d; no latch is inferred.
    ex_d = ex_q;
    if (flush_e) begin
      ex_d = '0;
    end else if (!stall_e) begin
      ex_d = '{cond: CondD, pcsrc: PCSrcD, regwrite: RegWriteD,
               memwrite: MemWriteD, branch: BranchD, nowrite: NoWriteD,
               flagw: FlagWD};
    end
  end

  // Execute control register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment keeps all registers updating in parallel.
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // Condition evaluation against the current flags {N,Z,C,V}.
  always_comb begin
    logic n, z, c, v, ge;
    {n, z, c, v} = flags_q;
    ge      = (n == v);
    cond_ex = 1'b0;
    case (ex_q.cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~(c & ~z);
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~z & ge;
      4'b1101: cond_ex = ~(~z & ge);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Next flags: hold while stalled (unless flushing), else update each half
  // independently when the instruction passes its condition.
  always_comb begin
    flags_d = flags_q;
    if (!(stall_e && !flush_e)) begin
      if (ex_q.flagw[1] && cond_ex) flags_d[3:2] = ALUFlagsE[3:2];
      if (ex_q.flagw[0] && cond_ex) flags_d[1:0] = ALUFlagsE[1:0];
    end
  end

  // Architectural flags register.
  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

  assign CondExE      = cond_ex;
  assign PCSrcE       = ex_q.pcsrc & cond_ex;
  assign RegWriteE    = ex_q.regwrite & cond_ex & ~ex_q.nowrite;
  assign MemWriteE    = ex_q.memwrite & cond_ex;
  assign BranchTakenE = ex_q.branch & cond_ex;
  assign FlagsE       = flags_q;

endmodule

// File: tb/tb_cond_unit_e.sv
// Testbench for cond_unit_e: a behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_cond_unit_e;

  logic       clk = 1'b0;
  logic       rst_n, stall_e, flush_e;
  logic [3:0] CondD;
  logic       PCSrcD, RegWriteD, MemWriteD, BranchD, NoWriteD;
  logic [1:0] FlagWD;
  logic [3:0] ALUFlagsE;
  logic       CondExE, PCSrcE, RegWriteE, MemWriteE, BranchTakenE;
  logic [3:0] FlagsE;

  int total = 0;
  int bad   = 0;

  cond_unit_e dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .CondD(CondD), .PCSrcD(PCSrcD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .NoWriteD(NoWriteD),
    .FlagWD(FlagWD), .ALUFlagsE(ALUFlagsE), .CondExE(CondExE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchTakenE(BranchTakenE), .FlagsE(FlagsE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0] cond;
    bit pcs, rw, mw, br, nw;
    bit [1:0] fw;
  } inst_t;

  inst_t      m_inst = '{4'h0, 0, 0, 0, 0, 0, 2'b00};
  logic [3:0] m_flags = 4'h0;

  // Conditions come in pairs: odd codes are the inverse of the even one.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;        // unsigned higher
      3'd5: base = (n == v);        // signed >=
      3'd6: base = !z && (n == v);  // signed >
      default: return (c == 4'hE);
    endcase
    return c[0] ? !base : base;
  endfunction

  always @(posedge clk) begin
    bit ok;
    ok = cond_ok(m_inst.cond, m_flags);
    if (!rst_n) begin
      m_flags = 4'h0;
      m_inst  = '{4'h0, 0, 0, 0, 0, 0, 2'b00};
    end else begin
      if (!stall_e || flush_e) begin
        if (ok && m_inst.fw[1]) m_flags[3:2] = ALUFlagsE[3:2];
        if (ok && m_inst.fw[0]) m_flags[1:0] = ALUFlagsE[1:0];
      end
      if (flush_e)       m_inst = '{4'h0, 0, 0, 0, 0, 0, 2'b00};
      else if (!stall_e) m_inst = '{CondD, PCSrcD, RegWriteD, MemWriteD, BranchD, NoWriteD, FlagWD};
    end
  end

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    bit ok;
    ok = cond_ok(m_inst.cond, m_flags);
    check("m_flags", FlagsE, m_flags);
    check("m_condex", {3'b0, CondExE}, {3'b0, ok});
    check("m_pcsrc", {3'b0, PCSrcE}, {3'b0, m_inst.pcs && ok});
    check("m_regwrite", {3'b0, RegWriteE}, {3'b0, m_inst.rw && ok && !m_inst.nw});
    check("m_memwrite", {3'b0, MemWriteE}, {3'b0, m_inst.mw && ok});
    check("m_branch", {3'b0, BranchTakenE}, {3'b0, m_inst.br && ok});
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_d(input logic [3:0] c, input bit pcs, input bit rw, input bit mw,
                       input bit br, input bit nw, input bit [1:0] fw);
    CondD = c; PCSrcD = pcs; RegWriteD = rw; MemWriteD = mw;
    BranchD = br; NoWriteD = nw; FlagWD = fw;
  endtask

  task automatic check_gated(input string name, input logic [3:0] exp);
    check(name, {PCSrcE, RegWriteE, MemWriteE, BranchTakenE}, exp);
  endtask

  initial begin
    rst_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0; ALUFlagsE = 4'hF;
    set_d(4'hE, 1, 1, 1, 1, 0, 2'b11);

    // Reset for two cycles with busy D inputs.
    cyc(); cyc();
    check("rst_flags", FlagsE, 4'h0);
    check_gated("rst_gated", 4'h0);
    check("rst_condex", {3'b0, CondExE}, 4'h0);
    rst_n = 1'b1;

    // CMP sets Z, then ADDEQ writes, ADDNE does not.
    set_d(4'hE, 0, 1, 0, 0, 1, 2'b11);
    cyc();
    check("cmp_regwrite", {3'b0, RegWriteE}, 4'h0);
    check("cmp_condex", {3'b0, CondExE}, 4'h1);
    ALUFlagsE = 4'b0100;
    set_d(4'h0, 0, 1, 0, 0, 0, 2'b00);
    cyc();
    check("cmp_flags", FlagsE, 4'b0100);
    check("addeq_regwrite", {3'b0, RegWriteE}, 4'h1);
    set_d(4'h1, 0, 1, 0, 0, 0, 2'b00);
    cyc();
    check("addne_regwrite", {3'b0, RegWriteE}, 4'h0);

    // Partial flag write: 1111 then update only N,Z with 0000.
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b11);
    cyc();
    ALUFlagsE = 4'hF;
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b10);
    cyc();
    check("set_all_flags", FlagsE, 4'hF);
    ALUFlagsE = 4'h0;
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b00);
    cyc();
    check("partial_flags", FlagsE, 4'b0011);

    // Failed condition suppresses branch and flag update.
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b11);
    cyc();
    ALUFlagsE = 4'h0;
    set_d(4'h0, 1, 0, 0, 1, 0, 2'b11);
    cyc();
    check("beq_flags0", FlagsE, 4'h0);
    check("beq_condex", {3'b0, CondExE}, 4'h0);
    check_gated("beq_gated", 4'h0);
    ALUFlagsE = 4'b1010;
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b00);
    cyc();
    check("beq_noflag", FlagsE, 4'h0);

    // Stall for 3 cycles with changing inputs: everything frozen.
    set_d(4'hE, 0, 1, 1, 0, 0, 2'b11);
    ALUFlagsE = 4'h0;
    cyc();
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d(4'(i + 1), 1, 0, 0, 1, 1, 2'(i));
      ALUFlagsE = 4'(4'hA + i);
      cyc();
      check("stall_flags", FlagsE, 4'h0);
      check_gated("stall_gated", 4'b0110);
      check("stall_condex", {3'b0, CondExE}, 4'h1);
    end

    // Stall with flush: pending flag update lands and a bubble enters.
    flush_e = 1'b1;
    ALUFlagsE = 4'b1001;
    cyc();
    check("flush_flags", FlagsE, 4'b1001);
    check_gated("flush_gated", 4'h0);
    check("flush_condex", {3'b0, CondExE}, 4'h0);
    stall_e = 1'b0; flush_e = 1'b0;

    // Reset mid-operation discards the flag-writing instruction in Execute.
    set_d(4'hE, 1, 1, 1, 1, 0, 2'b11);
    cyc();
    ALUFlagsE = 4'hF;
    rst_n = 1'b0;
    cyc();
    check("midrst_flags", FlagsE, 4'h0);
    check_gated("midrst_gated", 4'h0);
    rst_n = 1'b1;

    // Condition sweep: every code against every flag value.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        set_d(4'hE, 0, 0, 0, 0, 0, 2'b11);
        cyc();
        ALUFlagsE = 4'(f);
        set_d(4'(c), 0, 1, 0, 0, 0, 2'b00);
        cyc();
        check("sweep_flags", FlagsE, 4'(f));
        if (c == 14) check("sweep_al", {3'b0, RegWriteE}, 4'h1);
        if (c == 15) check("sweep_nv", {3'b0, RegWriteE}, 4'h0);
      end
    end

    // Pin a few sweep points by hand.
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b11);
    cyc();
    ALUFlagsE = 4'b1000;  // N=1, V=0: LT true, GE false
    set_d(4'hB, 0, 1, 0, 0, 0, 2'b00);
    cyc();
    check("lt_n1v0", {3'b0, RegWriteE}, 4'h1);
    set_d(4'hE, 0, 0, 0, 0, 0, 2'b11);
    cyc();
    ALUFlagsE = 4'b0010;  // C=1, Z=0: HI true
    set_d(4'h8, 0, 1, 0, 0, 0, 2'b00);
    cyc();
    check("hi_c1z0", {3'b0, RegWriteE}, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_unit_e.md
# cond_unit_e

Execute-stage conditional unit for the pipelined ARM core. It holds the decode-to-execute control pipeline register and the architectural NZCV flags register. Each cycle it evaluates the 4-bit condition field of the instruction in Execute against the current flags. It then gates that instruction's write, branch and flag-update controls before they pass to Memory.

## Interface
Parameters: none (widths fixed by the ISA).

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low: sampled on rising edge of clk; while 0, all state clears
- stall_e  in  1  hold Execute register contents; no flag update
- flush_e  in  1  load a bubble into the Execute register; has priority over stall_e
- CondD  in  4  condition field of the instruction in Decode
- PCSrcD  in  1  instruction writes the PC
- RegWriteD  in  1  instruction writes the register file
- MemWriteD  in  1  instruction writes memory
- BranchD  in  1  instruction is a branch
- NoWriteD  in  1  compare-type instruction; suppresses the register write
- FlagWD  in  2  [1] = update N,Z; [0] = update C,V
- ALUFlagsE  in  4  {N,Z,C,V} produced by the ALU for the instruction in Execute
- CondExE  out  1  condition of the Execute instruction is satisfied
- PCSrcE  out  1  gated PC write
- RegWriteE  out  1  gated register write
- MemWriteE  out  1  gated memory write
- BranchTakenE  out  1  gated branch
- FlagsE  out  4  current flags register {N,Z,C,V}

## Operation
- Execute register: CondE[3:0], PCSrcRegE, RegWriteRegE, MemWriteRegE, BranchRegE, NoWriteE, FlagWE[1:0].
- Register update on each rising edge, in priority order:
  - rst_n=0: all fields are 0.
  - flush_e=1: all fields are 0 (bubble).
  - stall_e=1: hold all fields.
  - Otherwise: load the corresponding D inputs.
- Condition encoding, with {N,Z,C,V}=FlagsE and ge=(N==V):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~(C&~Z)
  - 1010 GE: ge
  - 1011 LT: ~ge
  - 1100 GT: ~Z&ge
  - 1101 LE: ~(~Z&ge)
  - 1110 AL: 1
  - 1111: 0
- Combinational outputs:
  - CondExE = cond(CondE, FlagsE)
  - PCSrcE = PCSrcRegE & CondExE
  - RegWriteE = RegWriteRegE & CondExE & ~NoWriteE
  - MemWriteE = MemWriteRegE & CondExE
  - BranchTakenE = BranchRegE & CondExE
- Flags register update on each rising edge:
  - rst_n=0: flags become 4'b0000.
  - Else if stall_e=1 and flush_e=0: hold.
  - Else:
    - If FlagWE[1]&CondExE: N,Z take ALUFlagsE[3:2].
    - If FlagWE[0]&CondExE: C,V take ALUFlagsE[1:0].
    - Each half updates independently.
- flush_e asserted with stall_e: the current Execute instruction is treated as completing (its flags update applies) and a bubble enters.
- A failed condition suppresses every side effect, including the flag update.

## Timing
- Latency: D inputs appear in the Execute register, and therefore on the gated outputs, one cycle after capture.
- Flag visibility: an instruction's flag write is visible to the next instruction in Execute. There is no same-cycle bypass, because the instruction writing the flags and the instruction reading them are never in Execute together.
- Reset values:
  - FlagsE = 0000.
  - PCSrcE, RegWriteE, MemWriteE, BranchTakenE = 0.
  - CondExE = 0 (CondE=0000 EQ with Z=0).
- Bubble outputs: all gated outputs are 0; CondExE follows EQ on the current Z and is ignored downstream.
- Reset asserted mid-operation: the in-flight Execute instruction is discarded with no flag write; the next cycle behaves as post-reset.
- Stall: outputs stay constant except through flag changes; flags cannot change while stalled, so outputs are fully stable.

## Test plan
- Reset: rst_n=0 for 2 cycles with arbitrary D inputs -> FlagsE=0000; all gated outputs 0.
- Flag write, then conditional use:
  - Issue CMP (FlagWD=11, NoWriteD=1, RegWriteD=1, CondD=1110) with ALUFlagsE=0100 -> RegWriteE=0; next cycle FlagsE=0100.
  - Then issue ADDEQ (CondD=0000, RegWriteD=1) -> RegWriteE=1.
  - Then issue ADDNE -> RegWriteE=0.
- Partial flag write: FlagsE=1111, then an instruction with FlagWD=10 and ALUFlagsE=0000 -> FlagsE=0011.
- Failed condition: FlagsE=0000, BEQ with FlagWD=11 and ALUFlagsE=1010 -> BranchTakenE=0, PCSrcE=0, and FlagsE remains 0000.
- Stall/flush:
  - stall_e=1 for 3 cycles with changing D inputs and ALUFlagsE -> outputs and FlagsE are frozen.
  - stall_e=1 with flush_e=1 -> the current flag update applies and the next cycle has all gated outputs 0.
- Condition sweep: all 16 CondD values × all 16 flag values with RegWriteD=1 -> RegWriteE matches the encoding list; 1110 always gives 1 and 1111 always gives 0.
